// File: rtl/dummy_pkg.sv
// -----------------------------------------------------------------------------
// dummy_pkg
// Shared constants and helpers for the dummy_fifo family.
//   DUMMY_DATA_W_DEFAULT : default payload width in bits
//   clog2()              : ceiling log2, used to size pointers and level counter
// -----------------------------------------------------------------------------
package dummy_pkg;

    localparam int DUMMY_DATA_W_DEFAULT = 128;

    // Ceiling log2: number of bits needed to index 'value' entries.
    // clog2(1) = 0, clog2(4) = 2, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dummy_fifo_if.sv
// -----------------------------------------------------------------------------
// dummy_fifo_if
// Write/read handshake bundle of dummy_fifo.
//   wr_valid_i / wr_ready_o / data_in_i  : write channel (producer -> FIFO)
//   rd_valid_o / rd_ready_i / data_out_o : read channel  (FIFO -> consumer)
//   level_o, almost_full_o               : fill status
// Modports:
//   slave  : the FIFO side
//   master : the producer/consumer side
// -----------------------------------------------------------------------------
interface dummy_fifo_if
    import dummy_pkg::*;
#(
    parameter int DATA_W = DUMMY_DATA_W_DEFAULT,
    parameter int DEPTH  = 8
) ();

    localparam int LVL_W = clog2(DEPTH) + 1;

    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [DATA_W-1:0] data_in_i;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic [DATA_W-1:0] data_out_o;
    logic [LVL_W-1:0]  level_o;
    logic              almost_full_o;

    modport slave (
        input  wr_valid_i,
        input  data_in_i,
        input  rd_ready_i,
        output wr_ready_o,
        output rd_valid_o,
        output data_out_o,
        output level_o,
        output almost_full_o
    );

    modport master (
        output wr_valid_i,
        output data_in_i,
        output rd_ready_i,
        input  wr_ready_o,
        input  rd_valid_o,
        input  data_out_o,
        input  level_o,
        input  almost_full_o
    );

endinterface

// File: rtl/dummy_fifo_mem.sv
// -----------------------------------------------------------------------------
// dummy_fifo_mem
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port. Deliberately not reset: contents are only ever
// observed through the read pointer of a non-empty FIFO.
//   clk_i     : clock
//   wr_en_i   : write enable
//   wr_addr_i : write address
//   wr_data_i : write data (stored bit-exact, X/Z included)
//   rd_addr_i : read address
//   rd_data_o : combinational read data
// -----------------------------------------------------------------------------
module dummy_fifo_mem
    import dummy_pkg::*;
#(
    parameter int DATA_W = DUMMY_DATA_W_DEFAULT,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_r[rd_addr_i];

endmodule

// File: rtl/dummy_fifo.sv
// -----------------------------------------------------------------------------
// dummy_fifo
// Synchronous valid/ready FIFO with fill-level reporting, almost-full flag and
// synchronous flush.
//   clk_i      : clock, all state changes on rising edge
//   reset_n_i  : asynchronous active-low reset
//   clear_i    : synchronous flush; wins over any write/read in the same cycle
//   bus        : dummy_fifo_if.slave (write channel, read channel, status)
// Parameters:
//   DATA_W   : payload width
//   DEPTH    : number of entries, power of two, >= 2
//   AF_LEVEL : almost_full_o asserts when level >= AF_LEVEL (1..DEPTH)
// All flags are registered and computed from the next level, so there is no
// combinational path from rd_ready_i to wr_ready_o or wr_valid_i to rd_valid_o.
// -----------------------------------------------------------------------------
module dummy_fifo
    import dummy_pkg::*;
#(
    parameter int DATA_W   = DUMMY_DATA_W_DEFAULT,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         clear_i,
    dummy_fifo_if.slave  bus
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(32'd1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(32'd1);
    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(32'd0);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LEVEL);

    logic [PTR_W-1:0]  wr_ptr_r,      wr_ptr_next_s;
    logic [PTR_W-1:0]  rd_ptr_r,      rd_ptr_next_s;
    logic [LVL_W-1:0]  level_r,       level_next_s;
    logic              wr_ready_r,    wr_ready_next_s;
    logic              rd_valid_r,    rd_valid_next_s;
    logic              af_r,          af_next_s;
    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rd_data_s;

    // Handshake detection; memory write is suppressed when a flush wins.
    always_comb begin
        wr_fire_s = bus.wr_valid_i && wr_ready_r;
        rd_fire_s = rd_valid_r && bus.rd_ready_i;
        mem_we_s  = wr_fire_s && !clear_i;
    end

    // Next-state for pointers, level and the registered flags.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        level_next_s  = level_r;

        if (clear_i) begin
            wr_ptr_next_s = {PTR_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            level_next_s  = LVL_ZERO;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end

            if (rd_fire_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end

            // Simultaneous write and read leaves the level unchanged.
            case ({wr_fire_s, rd_fire_s})
                2'b10:   level_next_s = level_r + LVL_ONE;
                2'b01:   level_next_s = level_r - LVL_ONE;
                default: level_next_s = level_r;
            endcase
        end

        wr_ready_next_s = (level_next_s != LVL_FULL);
        rd_valid_next_s = (level_next_s != LVL_ZERO);
        af_next_s       = (level_next_s >= LVL_AF);
    end

    // State register: pointers, level and flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= LVL_ZERO;
            wr_ready_r <= 1'b1;
            rd_valid_r <= 1'b0;
            af_r       <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            level_r    <= level_next_s;
            wr_ready_r <= wr_ready_next_s;
            rd_valid_r <= rd_valid_next_s;
            af_r       <= af_next_s;
        end
    end

    dummy_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (mem_we_s),
        .wr_addr_i (wr_ptr_r),
        .wr_data_i (bus.data_in_i),
        .rd_addr_i (rd_ptr_r),
        .rd_data_o (mem_rd_data_s)
    );

    // Head-of-FIFO output, forced to zero while nothing valid is held so that
    // stale or uninitialised storage never reaches the consumer.
    always_comb begin
        if (rd_valid_r) begin
            bus.data_out_o = mem_rd_data_s;
        end else begin
            bus.data_out_o = {DATA_W{1'b0}};
        end
    end

    assign bus.wr_ready_o    = wr_ready_r;
    assign bus.rd_valid_o    = rd_valid_r;
    assign bus.level_o       = level_r;
    assign bus.almost_full_o = af_r;

endmodule

// File: tb/tb_dummy_fifo.sv
// -----------------------------------------------------------------------------
// tb_dummy_fifo
// Scoreboard bench for dummy_fifo (DEPTH=4, AF_LEVEL=2, DATA_W=32).
// Accepted writes push their payload into a queue; a separate monitor pops and
// compares whenever a read handshake is presented. Status outputs are checked
// every cycle against a small level model.
// -----------------------------------------------------------------------------
module tb_dummy_fifo;
    import dummy_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic clear   = 1'b0;

    dummy_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    dummy_fifo #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .clear_i   (clear),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];
    int exp_level = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare the head word at every read handshake.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && clear === 1'b0 &&
            bus.rd_valid_o === 1'b1 && bus.rd_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h, expected no word", bus.data_out_o);
            end else begin
                check("data_out", bus.data_out_o, sb.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; called at posedge+1.
    task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic clr);
        bit wacc;
        bit racc;
        bus.wr_valid_i = wv;
        bus.data_in_i  = wd;
        bus.rd_ready_i = rr;
        clear          = clr;
        @(negedge clk);
        #1;
        check("level_o",       DW'(bus.level_o),       DW'(exp_level));
        check("wr_ready_o",    DW'(bus.wr_ready_o),    DW'(exp_level != DEPTH));
        check("rd_valid_o",    DW'(bus.rd_valid_o),    DW'(exp_level != 0));
        check("almost_full_o", DW'(bus.almost_full_o), DW'(exp_level >= AF));
        wacc = wv && (exp_level != DEPTH) && !clr;
        racc = rr && (exp_level != 0) && !clr;
        if (clr) begin
            sb.delete();
            exp_level = 0;
        end else begin
            if (wacc) sb.push_back(wd);
            exp_level = exp_level + int'(wacc) - int'(racc);
        end
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] xw;
    logic [DW-1:0] zw;

    initial begin
        xw = 'x;
        zw = 'z;
        bus.wr_valid_i = 1'b0;
        bus.rd_ready_i = 1'b0;
        bus.data_in_i  = 'x;
        #1 reset_n = 1'b0;

        // Reset state with X on the data input.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_wr_ready",   DW'(bus.wr_ready_o),    DW'(1));
        check("rst_rd_valid",   DW'(bus.rd_valid_o),    DW'(0));
        check("rst_data_out",   bus.data_out_o,         DW'(0));
        check("rst_level",      DW'(bus.level_o),       DW'(0));
        check("rst_af",         DW'(bus.almost_full_o), DW'(0));
        check("rst_ctrl_known", DW'($isunknown({bus.wr_ready_o, bus.rd_valid_o,
                                                bus.level_o, bus.almost_full_o})), DW'(0));
        reset_n = 1'b1;

        // Fill to full; fifth word held off.
        for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        check("full_level", DW'(bus.level_o), DW'(4));

        // Full with simultaneous read and write: only the read goes.
        cyc(1'b1, 32'h5, 1'b1, 1'b0);
        cyc(1'b1, 32'h5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Wrap-around stream at one word per cycle.
        for (int i = 0; i < 12; i++) cyc(1'b1, 32'h10 + DW'(i), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush at level 3 while writing 0xAA.
        cyc(1'b1, 32'h21, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0);
        cyc(1'b1, 32'h23, 1'b0, 1'b0);
        cyc(1'b1, 32'hAA, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h31, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // X/Z payload round trip.
        cyc(1'b1, xw, 1'b0, 1'b0);
        cyc(1'b1, 32'h12345678, 1'b0, 1'b0);
        cyc(1'b1, zw, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle at level 2.
        cyc(1'b1, 32'h41, 1'b0, 1'b0);
        cyc(1'b1, 32'h42, 1'b0, 1'b0);
        bus.wr_valid_i = 1'b0;
        bus.rd_ready_i = 1'b0;
        check("pre_arst_level", DW'(bus.level_o), DW'(2));
        #2 reset_n = 1'b0;
        #1;
        check("arst_rd_valid", DW'(bus.rd_valid_o), DW'(0));
        check("arst_level",    DW'(bus.level_o),    DW'(0));
        check("arst_data_out", bus.data_out_o,      DW'(0));
        check("arst_wr_ready", DW'(bus.wr_ready_o), DW'(1));
        sb.delete();
        exp_level = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        check("sb_drained", DW'(sb.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
